// File: rtl/minisys_pkg.sv
// Shared types for the minisys memory subsystem: arbiter FSM states and
// requester identifiers used for grant ownership.
package minisys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single dmemory32 data port: CPU has priority,
// the debug/loader port wins after STARVE_LIM consecutive CPU grants.
module mem_port_arbiter
    import minisys_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int WCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(STARVE_LIM + 1);
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(MEM_LAT);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIM);

    state_t         state_reg;
    logic           we_reg;
    logic [WCW-1:0] wait_cnt_reg;
    logic [SCW-1:0] starve_cnt_reg;
    logic           grant_dbg;
    logic           any_req;

    // Debug wins when it is alone, or when the CPU has used up its streak.
    always_comb begin
        grant_dbg = 1'b0;
        if (dbg_req && (!cpu_req || starve_cnt_reg == STARVE_MAX)) begin
            grant_dbg = 1'b1;
        end
    end

    assign any_req = cpu_req | dbg_req;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            wait_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            owner          <= OWN_CPU;
            busy           <= 1'b0;
            cpu_ack        <= 1'b0;
            dbg_ack        <= 1'b0;
            cpu_rdata      <= '0;
            dbg_rdata      <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!dbg_req) begin
                        starve_cnt_reg <= '0;
                    end
                    if (any_req) begin
                        state_reg <= ISSUE;
                        busy      <= 1'b1;
                        // Strobes are registered here so they are high exactly in ISSUE.
                        if (grant_dbg) begin
                            owner          <= OWN_DBG;
                            we_reg         <= dbg_we;
                            mem_addr       <= dbg_addr;
                            mem_wdata      <= dbg_wdata;
                            mem_write      <= dbg_we;
                            mem_read       <= ~dbg_we;
                            starve_cnt_reg <= '0;
                        end else begin
                            owner     <= OWN_CPU;
                            we_reg    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_write <= cpu_we;
                            mem_read  <= ~cpu_we;
                            if (dbg_req && starve_cnt_reg != STARVE_MAX) begin
                                starve_cnt_reg <= starve_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        state_reg <= RESP;
                        cpu_ack   <= (owner == OWN_CPU);
                        dbg_ack   <= (owner == OWN_DBG);
                    end else begin
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= RESP;
                        if (owner == OWN_DBG) begin
                            dbg_rdata <= mem_rdata;
                            dbg_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-1 instance with a RAM model
// covers arbitration and handshakes, a latency-3 instance covers the wait length.
module tb_mem_port_arbiter;
    import minisys_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, dbg_ack, mem_read, mem_write, busy, owner;

    logic        c3_req, c3_we;
    logic [31:0] c3_addr, c3_wdata, c3_rdata, d3_rdata;
    logic        c3_ack, d3_ack;
    logic        z_req, z_we;
    logic [31:0] z_addr, z_wdata;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic        m3_read, m3_write, b3_busy, o3_owner;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIM(4)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_LIM(4)) u_lat3 (
        .clock(clock), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
        .dbg_req(z_req), .dbg_we(z_we), .dbg_addr(z_addr), .dbg_wdata(z_wdata),
        .dbg_rdata(d3_rdata), .dbg_ack(d3_ack),
        .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_read(m3_read),
        .mem_write(m3_write), .mem_rdata(m3_rdata), .busy(b3_busy), .owner(o3_owner)
    );

    // Memory models: read data is valid for exactly one cycle, poison otherwise.
    logic [31:0] ram1 [0:255];
    logic [31:0] ram3 [0:255];
    logic [31:0] pipe3 [0:2];
    logic [31:0] shadow [0:255];

    always @(posedge clock) begin
        if (mem_write) ram1[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_read ? ram1[mem_addr[9:2]] : 32'hBAD0_BAD0;
    end

    always @(posedge clock) begin
        if (m3_write) ram3[m3_addr[9:2]] <= m3_wdata;
        pipe3[0] <= m3_read ? ram3[m3_addr[9:2]] : 32'hBAD3_BAD3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m3_rdata = pipe3[2];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb3[$];
    int total = 0;
    int bad = 0;

    // Scoreboard consumer for the latency-1 instance.
    always @(negedge clock) begin
        if (reset && (cpu_ack || dbg_ack)) begin
            exp_t e;
            logic        got_port;
            logic [31:0] got_data;
            got_port = dbg_ack;
            got_data = dbg_ack ? dbg_rdata : cpu_rdata;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack port=%0d cyc=%0d required=no ack", got_port, cyc);
            end else begin
                e = sb.pop_front();
                $display("ack port=%0d we=%0d rdata=%h cyc=%0d", got_port, e.we, got_data, cyc);
                if ((cpu_ack && dbg_ack) || got_port !== e.port || cyc != e.ack_cyc
                    || (!e.we && got_data !== e.data)) begin
                    bad++;
                    $display("FAIL sb_ack port=%0d/%0d required=%0d cyc=%0d required=%0d rdata=%h required=%h",
                             cpu_ack, dbg_ack, e.port, cyc, e.ack_cyc, got_data, e.data);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat);
        int t0;
        @(negedge clock);
        if (port == OWN_DBG) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        t0 = cyc;
        @(negedge clock);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        total++;
        if (mem_read !== !we || mem_write !== we || mem_addr !== addr || owner !== port) begin
            bad++;
            $display("FAIL issue rd=%0d wr=%0d addr=%h own=%0d required rd=%0d wr=%0d addr=%h own=%0d",
                     mem_read, mem_write, mem_addr, owner, !we, we, addr, port);
        end
        if (we) begin
            total++;
            if (mem_wdata !== wdata) begin
                bad++;
                $display("FAIL issue_wdata got=%h required=%h", mem_wdata, wdata);
            end
            shadow[addr[9:2]] = wdata;
        end
        sb.push_back('{port: port, we: we, data: shadow[addr[9:2]], ack_cyc: t0 + lat});
        drain();
    endtask

    task automatic test_reset();
        int t0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if ({mem_read, mem_write, cpu_ack, dbg_ack, busy, owner} !== 6'b0
                || cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold rd=%0d wr=%0d acks=%0d%0d busy=%0d own=%0d rdata=%h addr=%h required all 0",
                         mem_read, mem_write, cpu_ack, dbg_ack, busy, owner, cpu_rdata, mem_addr);
            end
        end
        reset = 1'b1;
        t0 = cyc;
        @(negedge clock);
        cpu_req = 1'b0;
        total++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h10 || busy !== 1'b1) begin
            bad++;
            $display("FAIL first_issue rd=%0d wr=%0d addr=%h busy=%0d required 1 0 00000010 1",
                     mem_read, mem_write, mem_addr, busy);
        end
        sb.push_back('{port: OWN_CPU, we: 1'b0, data: 32'hDEADBEEF, ack_cyc: t0 + 3});
        @(negedge clock);
        total++;
        if (mem_read !== 1'b0) begin
            bad++;
            $display("FAIL read_strobe_width rd=%0d required=0", mem_read);
        end
        drain();
    endtask

    task automatic test_debug_write();
        access(OWN_DBG, 1'b1, 32'h20, 32'h12345678, 2);
        total++;
        if (dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL write_keeps_rdata got=%h required=00000000", dbg_rdata);
        end
        access(OWN_CPU, 1'b0, 32'h20, 32'h0, 3);
        access(OWN_DBG, 1'b0, 32'h20, 32'h0, 3);
    endtask

    task automatic test_contention();
        int t0;
        int n;
        int cnt;
        logic p;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h08;
        t0 = cyc;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            p = (cnt == 4);
            cnt = p ? 0 : cnt + 1;
            sb.push_back('{port: p, we: 1'b0, data: shadow[p ? 2 : 1], ack_cyc: t0 + 3 + 4 * k});
        end
        n = 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clock);
            if (cpu_ack || dbg_ack) n++;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL contention_acks got=%0d required=10", n);
        end
        drain();
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL contention_idle busy=%0d required=0", busy);
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        t0 = cyc;
        sb.push_back('{port: OWN_CPU, we: 1'b0, data: shadow[8], ack_cyc: t0 + 3});
        sb.push_back('{port: OWN_DBG, we: 1'b0, data: shadow[4], ack_cyc: t0 + 7});
        @(negedge clock);
        cpu_req = 1'b0;
        total++;
        if (owner !== OWN_CPU || mem_addr !== 32'h20) begin
            bad++;
            $display("FAIL simul_first own=%0d addr=%h required 0 00000020", owner, mem_addr);
        end
        repeat (4) @(negedge clock);
        total++;
        if (owner !== OWN_DBG || mem_addr !== 32'h10 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL simul_second own=%0d addr=%h rd=%0d required 1 00000010 1",
                     owner, mem_addr, mem_read);
        end
        dbg_req = 1'b0; dbg_addr = 32'h44; dbg_we = 1'b1; dbg_wdata = 32'hFFFF0000;
        @(negedge clock);
        total++;
        if (mem_addr !== 32'h10 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL latched_fields addr=%h wr=%0d required 00000010 0", mem_addr, mem_write);
        end
        drain();
        dbg_we = 1'b0;
    endtask

    task automatic test_lat3();
        int t0;
        int waits;
        int ack_at;
        exp_t e;
        @(negedge clock);
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h30;
        t0 = cyc;
        sb3.push_back('{port: OWN_CPU, we: 1'b0, data: 32'h3C00_000C, ack_cyc: t0 + 5});
        waits = 0;
        ack_at = -1;
        for (int i = 0; i < 20 && ack_at < 0; i++) begin
            @(negedge clock);
            c3_req = 1'b0;
            if (c3_ack) ack_at = cyc;
            else if (b3_busy && !m3_read) waits++;
        end
        e = sb3.pop_front();
        $display("ack lat3 rdata=%h cyc=%0d waits=%0d", c3_rdata, ack_at, waits);
        total++;
        if (ack_at != e.ack_cyc || c3_rdata !== e.data) begin
            bad++;
            $display("FAIL lat3_ack cyc=%0d required=%0d rdata=%h required=%h",
                     ack_at, e.ack_cyc, c3_rdata, e.data);
        end
        total++;
        if (waits != 3) begin
            bad++;
            $display("FAIL lat3_wait_cycles got=%0d required=3", waits);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
        @(negedge clock);
        cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        total++;
        if ({busy, cpu_ack, dbg_ack, owner, mem_read} !== 5'b0 || cpu_rdata !== 32'h0
            || dbg_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid busy=%0d acks=%0d%0d own=%0d rdata=%h/%h addr=%h required all 0",
                     busy, cpu_ack, dbg_ack, owner, cpu_rdata, dbg_rdata, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_no_ack ack=%0d busy=%0d required 0 0", cpu_ack, busy);
            end
        end
        access(OWN_CPU, 1'b0, 32'h0C, 32'h0, 3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i]   = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
            ram3[i]   = 32'h3C00_0000 | i;
        end
        ram1[4]   = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0;

        test_reset();
        test_debug_write();
        test_contention();
        test_simultaneous();
        test_lat3();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of dmemory32 between two requesters: the CPU load/store path and a debug/program-loader port used to preload or inspect RAM.
- Latches each granted transaction, issues a single-cycle read or write strobe to memory, and waits a parameterised read latency.
- Returns data with a one-cycle ack pulse to the owning requester.
- The CPU has priority, with a starvation limit so the debug port is always served eventually.

Parameters:
- MEM_LAT, 1, clock edges from the ISSUE cycle until mem_rdata is valid (legal range 1..7)
- STARVE_LIM, 4, consecutive CPU grants allowed while dbg_req is pending before the debug port wins

Ports:
- clock  in  1  system clock (cpuclk output)
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- dbg_req  in  1  debug access request
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  32  byte address
- dbg_wdata  in  32  write data
- dbg_rdata  out  32  read data, valid when dbg_ack=1
- dbg_ack  out  1  one-cycle completion pulse
- mem_addr  out  32  address to dmemory32
- mem_wdata  out  32  write data to dmemory32
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_rdata  in  32  read data from dmemory32
- busy  out  1  1 in any state other than IDLE
- owner  out  1  current/last grant: 0=CPU, 1=DBG

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-low; it is sampled only on the rising edge of clock.
- Reset values: state=IDLE; all acks, strobes and busy = 0; owner=0; cpu_rdata, dbg_rdata, mem_addr, mem_wdata = 0; wait counter and starve counter = 0.
- States: IDLE, ISSUE, WAIT, RESP. Encoding is 2 bits.
- IDLE:
  - No request: remain in IDLE.
  - Any request: grant one requester, then latch owner, addr, we and wdata into mem_addr, mem_wdata and an internal we flag. Next state is ISSUE.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless starve_cnt == STARVE_LIM, in which case DBG wins.
  - starve_cnt increments (saturating at STARVE_LIM) on a CPU grant while dbg_req=1.
  - starve_cnt clears on a DBG grant, and whenever dbg_req=0 in IDLE.
- ISSUE (exactly 1 cycle): mem_write=we or mem_read=~we.
  - Write: next state is RESP.
  - Read: load wait_cnt=MEM_LAT, next state is WAIT.
- WAIT: wait_cnt decrements each cycle.
  - When wait_cnt==1, mem_rdata is captured at the end of that cycle into the owner's rdata register. Next state is RESP.
  - WAIT therefore lasts MEM_LAT cycles.
- RESP (1 cycle): owner's ack=1, then next state is IDLE. The non-owner's ack stays 0.
- Latency, with the request sampled in IDLE at cycle t:
  - Write: ack at t+2.
  - Read: ack at t+2+MEM_LAT (t+3 with the default).
- Handshake:
  - The arbiter latches all request fields at grant, so later changes to them are ignored.
  - A request still high in IDLE after an ack is treated as a new request, so a requester deasserts req in its ack cycle unless issuing back-to-back.
  - A losing requester keeps req high and waits; there is no timeout.
- rdata registers hold their value until the next read completion for that port. Writes never modify rdata.
- mem_addr and mem_wdata hold the last latched values between transactions. Strobes are asserted only in ISSUE.
- Reset mid-operation (any state): the in-flight access is dropped with no ack, and all state returns to reset values on that edge. A memory write strobe already issued is not undone.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

Decomposition:
- Shared package minisys_pkg:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - owner constants OWN_CPU=1'b0, OWN_DBG=1'b1
- No sub-module required. Arbitration plus the starvation counter is small enough to stay inline.
- If the debug port grows, factor the grant logic out as mem_arb_grant.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles with cpu_req=1 → no strobes, acks 0, busy 0. After release, the read to addr 0x10 (RAM holds 0xDEADBEEF) gives mem_read high for 1 cycle and cpu_ack at t+3 with cpu_rdata=0xDEADBEEF.
- Debug write: dbg_req=1, dbg_we=1, addr 0x20, data 0x12345678 → mem_write pulse with those values, dbg_ack at t+2. A subsequent CPU read of 0x20 returns 0x12345678.
- Contention: cpu_req and dbg_req held continuously (STARVE_LIM=4) → grant order CPU,CPU,CPU,CPU,DBG,CPU... and starve_cnt clears after the DBG grant.
- Simultaneous request in IDLE with starve_cnt=0 → CPU served first. DBG is granted in the IDLE after cpu_ack, with its latched fields unaffected by toggling dbg_addr during the wait.
- MEM_LAT=3 instance: CPU read → exactly 3 WAIT cycles, ack at t+5, data sampled in the last WAIT cycle.
- Reset asserted during WAIT → next cycle in IDLE, no ack, rdata=0. A new request after release completes normally.
